// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and constants for the parametrised register file
package regfile_pkg;

   typedef enum logic {
      S_INIT,
      S_RUN
   } rf_state_t;

   localparam logic [63:0] ZERO_WORD = 64'h0;

   function automatic int depth_of(input int addr_w);
      return 1 << addr_w;
   endfunction

endpackage

// File: rtl/regfile_rdport.sv
// rtl/regfile_rdport.sv - one read port: address/enable mux, zero-entry gating, bypass, optional output register
module regfile_rdport
   import regfile_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 2,
   parameter int READ_LAT  = 1,
   parameter int ZERO_REG0 = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              busy,
   input  logic              re,
   input  logic [ADDR_W-1:0] ra,
   input  logic [DATA_W-1:0] mem [2**ADDR_W],
   input  logic              wr_acc,
   input  logic [ADDR_W-1:0] wa,
   input  logic [DATA_W-1:0] wd,
   output logic [DATA_W-1:0] rdata
);

   logic              zero_hit;
   logic [DATA_W-1:0] comb_data;
   logic [DATA_W-1:0] rdata_d;
   logic [DATA_W-1:0] rdata_q;

   always_comb begin
      zero_hit  = (ZERO_REG0 != 0) && (ra == '0);
      comb_data = (re && !zero_hit) ? mem[ra] : ZERO_WORD[DATA_W-1:0];
      if (busy || !re || zero_hit) begin
         rdata_d = ZERO_WORD[DATA_W-1:0];
      end else if (wr_acc && (wa == ra)) begin
         rdata_d = wd;
      end else begin
         rdata_d = mem[ra];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= ZERO_WORD[DATA_W-1:0];
      end else begin
         rdata_q <= rdata_d;
      end
   end

   // The register exists in both modes; with READ_LAT=0 it is simply unused downstream.
   assign rdata = (READ_LAT == 0) ? comb_data : rdata_q;

endmodule

// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - parametrised two-read-port register file with hardware clear sequencer
module regfile_param
   import regfile_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 2,
   parameter int READ_LAT  = 1,
   parameter int ZERO_REG0 = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic [DATA_W-1:0] D,
   input  logic [ADDR_W-1:0] WA,
   input  logic              WE,
   input  logic [ADDR_W-1:0] RAA,
   input  logic [ADDR_W-1:0] RBA,
   input  logic              RAE,
   input  logic              RBE,
   output logic [DATA_W-1:0] portA,
   output logic [DATA_W-1:0] portB,
   output logic              busy,
   output logic              wr_err
);

   localparam int DEPTH = depth_of(ADDR_W);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   rf_state_t         state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic              wr_err_q, wr_err_d;
   logic              wr_acc;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mem_d    = mem_q;
      wr_err_d = 1'b0;
      wr_acc   = 1'b0;
      case (state_q)
         S_INIT: begin
            mem_d[cnt_q] = ZERO_WORD[DATA_W-1:0];
            cnt_d        = cnt_q + ADDR_W'(1);
            wr_err_d     = WE;
            if (cnt_q == ADDR_W'(DEPTH - 1)) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            // clr wins over a same-cycle write, which is dropped without flagging.
            if (clr) begin
               state_d = S_INIT;
               cnt_d   = '0;
            end else if (WE && !((ZERO_REG0 != 0) && (WA == '0))) begin
               wr_acc    = 1'b1;
               mem_d[WA] = D;
            end
         end
         default: begin
            state_d = S_INIT;
            cnt_d   = '0;
         end
      endcase
      busy_d = (state_d == S_INIT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_INIT;
         cnt_q    <= '0;
         busy_q   <= 1'b1;
         wr_err_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         wr_err_q <= wr_err_d;
         mem_q    <= mem_d;
      end
   end

   regfile_rdport #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .READ_LAT (READ_LAT),
      .ZERO_REG0(ZERO_REG0)
   ) u_rd_a (
      .clk   (clk),
      .rst   (rst),
      .busy  (busy_q),
      .re    (RAE),
      .ra    (RAA),
      .mem   (mem_q),
      .wr_acc(wr_acc),
      .wa    (WA),
      .wd    (D),
      .rdata (portA)
   );

   regfile_rdport #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .READ_LAT (READ_LAT),
      .ZERO_REG0(ZERO_REG0)
   ) u_rd_b (
      .clk   (clk),
      .rst   (rst),
      .busy  (busy_q),
      .re    (RBE),
      .ra    (RBA),
      .mem   (mem_q),
      .wr_acc(wr_acc),
      .wa    (WA),
      .wd    (D),
      .rdata (portB)
   );

   assign busy   = busy_q;
   assign wr_err = wr_err_q;

endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - scoreboard bench for regfile_param in registered, combinational and zero-entry builds
module tb_regfile_param;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clr = 1'b0;
   logic [7:0] D   = '0;
   logic [1:0] WA  = '0;
   logic       WE  = 1'b0;
   logic [1:0] RAA = '0;
   logic [1:0] RBA = '0;
   logic       RAE = 1'b0;
   logic       RBE = 1'b0;

   logic [7:0] pa1, pb1, pa0, pb0, paz, pbz;
   logic       busy1, werr1, busy0, werr0, busyz, werrz;

   int  cyc    = 0;
   int  checks = 0;
   int  errors = 0;
   bit  done   = 1'b0;

   int         q_due[$];
   int         q_sig[$];
   logic [7:0] q_exp[$];
   string      q_name[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   regfile_param #(.DATA_W(8), .ADDR_W(2), .READ_LAT(1), .ZERO_REG0(0)) u_dut1 (
      .clk(clk), .rst(rst), .clr(clr), .D(D), .WA(WA), .WE(WE), .RAA(RAA), .RBA(RBA),
      .RAE(RAE), .RBE(RBE), .portA(pa1), .portB(pb1), .busy(busy1), .wr_err(werr1));

   regfile_param #(.DATA_W(8), .ADDR_W(2), .READ_LAT(0), .ZERO_REG0(0)) u_dut0 (
      .clk(clk), .rst(rst), .clr(clr), .D(D), .WA(WA), .WE(WE), .RAA(RAA), .RBA(RBA),
      .RAE(RAE), .RBE(RBE), .portA(pa0), .portB(pb0), .busy(busy0), .wr_err(werr0));

   regfile_param #(.DATA_W(8), .ADDR_W(2), .READ_LAT(1), .ZERO_REG0(1)) u_dutz (
      .clk(clk), .rst(rst), .clr(clr), .D(D), .WA(WA), .WE(WE), .RAA(RAA), .RBA(RBA),
      .RAE(RAE), .RBE(RBE), .portA(paz), .portB(pbz), .busy(busyz), .wr_err(werrz));

   localparam int S_PA1 = 0, S_PB1 = 1, S_BUSY1 = 2, S_WERR1 = 3;
   localparam int S_PA0 = 4, S_PB0 = 5, S_PAZ = 6, S_BUSY0 = 7, S_WERR0 = 8;

   function automatic logic [7:0] sample(input int id);
      case (id)
         S_PA1:   return pa1;
         S_PB1:   return pb1;
         S_BUSY1: return {7'b0, busy1};
         S_WERR1: return {7'b0, werr1};
         S_PA0:   return pa0;
         S_PB0:   return pb0;
         S_PAZ:   return paz;
         S_BUSY0: return {7'b0, busy0};
         S_WERR0: return {7'b0, werr0};
         default: return 8'hxx;
      endcase
   endfunction

   task automatic chk(input int sig, input logic [7:0] e, input int lat, input string nm);
      q_due.push_back(cyc + lat);
      q_sig.push_back(sig);
      q_exp.push_back(e);
      q_name.push_back(nm);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      int n;
      logic [7:0] act;
      n = q_due.size();
      for (int i = 0; i < n; i++) begin
         int d;
         int s;
         logic [7:0] e;
         string nm;
         d  = q_due.pop_front();
         s  = q_sig.pop_front();
         e  = q_exp.pop_front();
         nm = q_name.pop_front();
         if (d == cyc) begin
            checks++;
            act = sample(s);
            if (act !== e) begin
               errors++;
               $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, e);
            end
         end else begin
            q_due.push_back(d);
            q_sig.push_back(s);
            q_exp.push_back(e);
            q_name.push_back(nm);
         end
      end
      if (done) begin
         if (q_due.size() > 0) begin
            errors += q_due.size();
            $display("FAIL drain pending=%0d expected=0", q_due.size());
         end
         $display("CHECKS %0d ERRORS %0d", checks, errors);
         $finish;
      end
   end

   initial begin
      logic [7:0] v;
      // Reset: busy for exactly DEPTH cycles after the reset edge.
      tick();
      rst = 1'b0;
      chk(S_PA1, 8'h00, 0, "reset_portA");
      chk(S_WERR1, 8'h00, 0, "reset_wr_err");
      for (int k = 0; k < 4; k++) chk(S_BUSY1, 8'h01, k, "init_busy");
      chk(S_BUSY1, 8'h00, 4, "init_done");
      chk(S_BUSY0, 8'h00, 4, "init_done_lat0");
      repeat (4) tick();

      for (int a = 0; a < 4; a++) begin
         RAA = 2'(a); RBA = 2'(a); RAE = 1'b1; RBE = 1'b1;
         chk(S_PA1, 8'h00, 1, "post_init_rdA");
         chk(S_PB1, 8'h00, 1, "post_init_rdB");
         chk(S_PA0, 8'h00, 0, "post_init_rdA_lat0");
         chk(S_PAZ, 8'h00, 1, "post_init_rdA_z");
         tick();
      end

      // Plain write then read, and read-enable gating.
      RAE = 1'b0; RBE = 1'b0;
      WE = 1'b1; WA = 2'd2; D = 8'hA5;
      tick();
      WE = 1'b0; RAA = 2'd2; RAE = 1'b1;
      chk(S_PA1, 8'hA5, 1, "write_read");
      chk(S_PA0, 8'hA5, 0, "write_read_lat0");
      tick();
      RAE = 1'b0;
      chk(S_PA1, 8'h00, 1, "rae_low");
      chk(S_PA0, 8'h00, 0, "rae_low_lat0");
      tick();

      // Same-cycle write/read: bypass in registered mode, old value when combinational.
      WE = 1'b1; WA = 2'd3; D = 8'h3C; RBA = 2'd3; RBE = 1'b1;
      chk(S_PB1, 8'h3C, 1, "bypass");
      chk(S_PB0, 8'h00, 0, "no_bypass_lat0_old");
      chk(S_PB0, 8'h3C, 1, "no_bypass_lat0_new");
      tick();
      WE = 1'b0;
      tick();
      RBE = 1'b0;

      // Entry 0 write: stored normally, discarded in the zero-entry build.
      WE = 1'b1; WA = 2'd0; D = 8'hFF; RAA = 2'd0; RAE = 1'b1;
      chk(S_PAZ, 8'h00, 1, "zero_bypass");
      chk(S_PA1, 8'hFF, 1, "addr0_bypass");
      tick();
      WE = 1'b0;
      chk(S_PAZ, 8'h00, 1, "zero_read");
      chk(S_PA1, 8'hFF, 1, "addr0_read");
      chk(S_PA0, 8'hFF, 0, "addr0_read_lat0");
      tick();
      RAE = 1'b0;

      for (int a = 0; a < 4; a++) begin
         WE = 1'b1; WA = 2'(a); D = 8'(17 * (a + 1));
         tick();
      end
      WE = 1'b0;
      for (int a = 0; a < 4; a++) begin
         v = 8'(17 * (a + 1));
         RAA = 2'(a); RBA = 2'(a); RAE = 1'b1; RBE = 1'b1;
         chk(S_PA1, v, 1, "fill_rdA");
         chk(S_PB1, v, 1, "fill_rdB");
         chk(S_PB0, v, 0, "fill_rdB_lat0");
         chk(S_PAZ, (a == 0) ? 8'h00 : v, 1, "fill_rdA_z");
         tick();
      end

      // clr with a same-cycle write: write dropped silently, then DEPTH busy cycles.
      clr = 1'b1; WE = 1'b1; WA = 2'd1; D = 8'h77; RAA = 2'd1; RAE = 1'b1;
      chk(S_PA1, 8'h22, 1, "clr_drops_write");
      chk(S_WERR1, 8'h00, 1, "clr_no_wr_err");
      chk(S_BUSY1, 8'h00, 0, "clr_cycle_busy");
      for (int k = 1; k <= 4; k++) chk(S_BUSY1, 8'h01, k, "clr_busy");
      chk(S_BUSY1, 8'h00, 5, "clr_done");
      tick();
      clr = 1'b0; WE = 1'b1; WA = 2'd2; D = 8'h99;
      chk(S_WERR1, 8'h01, 1, "busy_wr_err");
      chk(S_WERR0, 8'h01, 1, "busy_wr_err_lat0");
      chk(S_PA1, 8'h00, 1, "busy_read_zero");
      tick();
      WE = 1'b0;
      chk(S_WERR1, 8'h00, 1, "wr_err_pulse_end");
      repeat (3) tick();
      for (int a = 0; a < 4; a++) begin
         RAA = 2'(a); RBA = 2'(a); RAE = 1'b1; RBE = 1'b1;
         chk(S_PA1, 8'h00, 1, "cleared_rdA");
         chk(S_PB1, 8'h00, 1, "cleared_rdB");
         chk(S_PA0, 8'h00, 0, "cleared_rdA_lat0");
         tick();
      end
      RAE = 1'b0; RBE = 1'b0;

      // Reset at INIT cycle 2 restarts the sweep from the reset edge.
      clr = 1'b1;
      tick();
      clr = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      for (int k = 1; k <= 4; k++) chk(S_BUSY1, 8'h01, k, "rst_mid_init_busy");
      chk(S_BUSY1, 8'h00, 5, "rst_mid_init_done");
      chk(S_WERR1, 8'h00, 1, "rst_wr_err");
      tick();
      rst = 1'b0;

      for (int k = 0; k < 12 && q_due.size() > 0; k++) tick();
      done = 1'b1;
   end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised successor to the 4x8 two-read-port register file.
- Generalised in data width, depth and read latency, with optional hard-wired zero entry 0 and write-to-read bypass.
- Adds a post-reset/on-demand hardware clear sequencer with busy status and dropped-write flag.
- Sits in the datapath as the operand store feeding ALU operand ports A and B.

Parameters:
- DATA_W, 8, entry width in bits (1..64)
- ADDR_W, 2, address width; DEPTH = 2**ADDR_W entries
- READ_LAT, 1, 0 = combinational read, 1 = registered read with write bypass
- ZERO_REG0, 0, 1 = entry 0 always reads 0 and writes to it are ignored

Ports:
- clk  in  1  rising-edge clock, sole clock domain
- rst  in  1  synchronous active-high reset
- clr  in  1  request hardware clear of all entries (sampled in RUN only)
- D  in  DATA_W  write data
- WA  in  ADDR_W  write address
- WE  in  1  write enable
- RAA  in  ADDR_W  port A read address
- RBA  in  ADDR_W  port B read address
- RAE  in  1  port A read enable
- RBE  in  1  port B read enable
- portA  out  DATA_W  port A read data
- portB  out  DATA_W  port B read data
- busy  out  1  high while clearing; writes are dropped
- wr_err  out  1  one-cycle pulse: WE was asserted while busy

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=INIT, clear counter=0, busy=1, wr_err=0, portA=portB=0 (registered mode). Storage is not reset directly; the INIT sweep zeroes it.

FSM states:
- INIT:
  - Each cycle, entry[cnt] <= 0 and cnt <= cnt+1.
  - When cnt==DEPTH-1, the next state is RUN.
  - INIT therefore lasts exactly DEPTH cycles after the reset edge; busy=1 throughout.
- RUN:
  - busy=0.
  - clr=1 moves to INIT with cnt=0 on the next edge. clr outranks a same-cycle WE, which is dropped silently (no wr_err).
- rst asserted mid-INIT restarts the sweep at cnt=0. clr is ignored while in INIT.

Writes:
- In RUN, WE=1 writes D into entry[WA] at the edge.
- With ZERO_REG0=1, writes where WA==0 are discarded.
- In INIT, WE=1 is discarded and wr_err=1 on the following cycle.

Reads, READ_LAT=0:
- portA = RAE ? entry[RAA] : 0, combinational.
- A write becomes visible after the edge; there is no bypass.
- During INIT, reads return current storage contents. These are zero for entries already swept and stale for the rest; consumers must honour busy.

Reads, READ_LAT=1:
- portA is registered on the edge:
  - busy or !RAE -> 0
  - else WE && WA==RAA (write accepted) -> D (bypass)
  - else entry[RAA]
- Latency is 1 cycle. portB is identical using RBA/RBE.

Zero entry:
- With ZERO_REG0=1, an address of 0 always yields 0, in both modes and with or without bypass.

Other rules:
- Both ports may read the same address in the same cycle; both return the same value.
- No width conversion: D and portA/portB are all DATA_W. Addresses cover DEPTH exactly, so there is no out-of-range case.

Decomposition:
- regfile_pkg:
  - rf_state_t enum {S_INIT, S_RUN}
  - localparam function for DEPTH
  - constant for the zero word
- Sub-module regfile_rdport (address/enable mux, zero-reg gating, bypass, optional output register per READ_LAT), instantiated twice for ports A and B.
- Storage, write logic and clear FSM remain in the top module.

Test Plan (DATA_W=8, ADDR_W=2, READ_LAT=1 unless stated):
- Reset: rst high 1 cycle, then low -> busy=1 for exactly 4 cycles, then 0. Reads of all 4 addresses return 0x00.
- Write 0xA5 to WA=2, then RAA=2, RAE=1 on the next cycle -> portA=0xA5 one cycle later. With RAE=0 -> portA=0x00.
- Same-cycle WE=1, WA=3, D=0x3C, with RBA=3, RBE=1 -> portB=0x3C after one edge (bypass). Repeat with READ_LAT=0 -> portB shows the old value that cycle and 0x3C after the edge.
- ZERO_REG0=1: write 0xFF to WA=0 -> RAA=0 reads 0x00. Bypass is also suppressed for address 0.
- After filling all entries with 0x11..0x44, pulse clr together with WE(WA=1, D=0x77):
  - The write is dropped with no wr_err.
  - busy=1 for 4 cycles, and a WE during busy gives a wr_err pulse the next cycle.
  - Afterwards, all reads return 0x00.
- Assert rst at INIT cycle 2 -> sweep restarts, busy stays high for 4 more cycles from the reset edge.
